// File: rtl/cache_assoc_ctrl.sv
// Set-associative cache controller: hit/miss FSM, tree-PLRU replacement, write-back/refill handshakes.
// Optional set/way flush walk is compiled in when CACHE_ASSOC_CTRL_FLUSH_EN is defined.
module cache_assoc_ctrl #(
  parameter int p_num_ways = 2,
  parameter int p_num_sets = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          memreq_val_i,
  output logic                          memreq_rdy_o,
  input  logic                          memreq_type_i,
  input  logic [$clog2(p_num_sets)-1:0] memreq_idx_i,
  output logic                          memresp_val_o,
  input  logic                          memresp_rdy_i,
  input  logic [p_num_ways-1:0]         tag_match_i,
  input  logic [p_num_ways-1:0]         dirty_i,
  output logic [$clog2(p_num_ways)-1:0] way_sel_o,
  output logic                          darray_wen_o,
  output logic                          tarray_wen_o,
  output logic                          dirty_wen_o,
  output logic                          dirty_wdata_o,
  output logic                          mem_req_val_o,
  input  logic                          mem_req_rdy_i,
  output logic                          mem_req_rw_o,
  input  logic                          mem_resp_val_i,
  output logic                          mem_resp_rdy_o,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic [$clog2(p_num_sets)-1:0] flush_idx_o
);

  localparam int WW = $clog2(p_num_ways);
  localparam int IW = $clog2(p_num_sets);

  typedef enum logic [2:0] {
    IDLE, EVICT, REFILL_REQ, REFILL_WAIT, RESP
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
    , FLUSH, FLUSH_FIN
`endif
  } state_e;

  state_e                state_q, state_d;
  logic                  type_q, type_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WW-1:0]         way_q, way_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [p_num_ways-2:0] plru_q [p_num_sets];
  logic                  plru_we;
  logic [IW-1:0]         plru_idx;
  logic [WW-1:0]         plru_way;
  logic [WW-1:0]         hit_way;
  logic [WW-1:0]         victim;

  // Tree walk from the root: a 0 bit steers left (lower ways), so a freshly reset set evicts way 0.
  function automatic logic [WW-1:0] plruVictim(input logic [p_num_ways-2:0] bits);
    logic [WW:0] node;
    node = WW'(1) == '0 ? '0 : (WW+1)'(1);
    for (int l = 0; l < WW; l++) node = {node[WW-1:0], bits[node-1]};
    return node[WW-1:0];
  endfunction

  function automatic logic [p_num_ways-2:0] plruUpdate(input logic [p_num_ways-2:0] bits,
                                                       input logic [WW-1:0] way);
    logic [p_num_ways-2:0] res;
    logic [WW:0]           node;
    logic                  d;
    res  = bits;
    node = (WW+1)'(1);
    for (int l = 0; l < WW; l++) begin
      d             = way[WW-1-l];
      res[node-1]   = ~d;
      node          = {node[WW-1:0], d};
    end
    return res;
  endfunction

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < p_num_ways; i++)
      if (tag_match_i[i]) hit_way = hit_way | WW'(i);
  end

  assign victim = plruVictim(plru_q[memreq_idx_i]);

`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
  logic [IW-1:0] fidx_q, fidx_d;
  logic [WW-1:0] fway_q, fway_d;
  logic          flush_adv;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_done_o = 1'b0;
  assign flush_idx_o  = '0;
`endif

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    idx_d         = idx_q;
    way_d         = way_q;
    wr_pend_d     = 1'b0;
    plru_we       = 1'b0;
    plru_idx      = idx_q;
    plru_way      = way_q;
    memreq_rdy_o  = 1'b0;
    memresp_val_o = 1'b0;
    way_sel_o     = '0;
    darray_wen_o  = 1'b0;
    tarray_wen_o  = 1'b0;
    dirty_wen_o   = 1'b0;
    dirty_wdata_o = 1'b0;
    mem_req_val_o = 1'b0;
    mem_req_rw_o  = 1'b0;
    mem_resp_rdy_o = 1'b0;
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
    flush_done_o  = 1'b0;
    flush_idx_o   = '0;
    fidx_d        = fidx_q;
    fway_d        = fway_q;
    flush_adv     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
        if (flush_i && reset_ni) begin
          state_d = FLUSH;
          fidx_d  = '0;
          fway_d  = '0;
        end else
`endif
        begin
          memreq_rdy_o = reset_ni;
          if (memreq_val_i && reset_ni) begin
            type_d = memreq_type_i;
            idx_d  = memreq_idx_i;
            if (|tag_match_i) begin
              memresp_val_o = 1'b1;
              way_sel_o     = hit_way;
              darray_wen_o  = memreq_type_i;
              dirty_wen_o   = memreq_type_i;
              dirty_wdata_o = memreq_type_i;
              plru_we       = 1'b1;
              plru_idx      = memreq_idx_i;
              plru_way      = hit_way;
              way_d         = hit_way;
              if (!memresp_rdy_i) state_d = RESP;
            end else begin
              way_d   = victim;
              state_d = dirty_i[victim] ? EVICT : REFILL_REQ;
            end
          end
        end
      end
      EVICT: begin
        mem_req_val_o = 1'b1;
        mem_req_rw_o  = 1'b1;
        way_sel_o     = way_q;
        if (mem_req_rdy_i) begin
          dirty_wen_o = 1'b1;
          state_d     = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        mem_req_val_o = 1'b1;
        way_sel_o     = way_q;
        if (mem_req_rdy_i) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        mem_resp_rdy_o = 1'b1;
        way_sel_o      = way_q;
        if (mem_resp_val_i) begin
          tarray_wen_o = 1'b1;
          darray_wen_o = 1'b1;
          plru_we      = 1'b1;
          wr_pend_d    = type_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        // A write miss merges its store data here, one cycle after the refill lands.
        memresp_val_o = 1'b1;
        way_sel_o     = way_q;
        darray_wen_o  = wr_pend_q;
        dirty_wen_o   = wr_pend_q;
        dirty_wdata_o = wr_pend_q;
        if (memresp_rdy_i) state_d = IDLE;
      end
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
      FLUSH: begin
        flush_idx_o = fidx_q;
        way_sel_o   = fway_q;
        flush_adv   = 1'b1;
        if (dirty_i[fway_q]) begin
          mem_req_val_o = 1'b1;
          mem_req_rw_o  = 1'b1;
          flush_adv     = mem_req_rdy_i;
          dirty_wen_o   = mem_req_rdy_i;
        end
        if (flush_adv) begin
          fway_d = fway_q + WW'(1);
          if (&fway_q) begin
            fidx_d = fidx_q + IW'(1);
            if (&fidx_q) state_d = FLUSH_FIN;
          end
        end
      end
      FLUSH_FIN: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      type_q    <= 1'b0;
      idx_q     <= '0;
      way_q     <= '0;
      wr_pend_q <= 1'b0;
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
      fidx_q    <= '0;
      fway_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      idx_q     <= idx_d;
      way_q     <= way_d;
      wr_pend_q <= wr_pend_d;
`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
      fidx_q    <= fidx_d;
      fway_q    <= fway_d;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < p_num_sets; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[plru_idx] <= plruUpdate(plru_q[plru_idx], plru_way);
    end
  end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Self-checking bench for cache_assoc_ctrl (2 ways, 16 sets): directed scenarios plus random hit/miss traffic
// checked against a per-set "next victim" model; flush checks follow CACHE_ASSOC_CTRL_FLUSH_EN.
module tb_cache_assoc_ctrl;

  localparam int W = 2;
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       memreq_val, memreq_rdy, memreq_type;
  logic [3:0] memreq_idx;
  logic       memresp_val, memresp_rdy;
  logic [1:0] tag_match, dirty;
  logic       way_sel;
  logic       darray_wen, tarray_wen, dirty_wen, dirty_wdata;
  logic       mem_req_val, mem_req_rdy, mem_req_rw;
  logic       mem_resp_val, mem_resp_rdy;
  logic       flush, flush_done;
  logic [3:0] flush_idx;

  int compared   = 0;
  int mismatched = 0;

  // With two ways the PLRU tree is one bit: the next victim is whichever way was not touched last.
  int nextVictim [S];

  always #5 clk = ~clk;

  cache_assoc_ctrl #(.p_num_ways(W), .p_num_sets(S)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .memreq_val_i(memreq_val), .memreq_rdy_o(memreq_rdy), .memreq_type_i(memreq_type),
    .memreq_idx_i(memreq_idx), .memresp_val_o(memresp_val), .memresp_rdy_i(memresp_rdy),
    .tag_match_i(tag_match), .dirty_i(dirty), .way_sel_o(way_sel),
    .darray_wen_o(darray_wen), .tarray_wen_o(tarray_wen), .dirty_wen_o(dirty_wen),
    .dirty_wdata_o(dirty_wdata), .mem_req_val_o(mem_req_val), .mem_req_rdy_i(mem_req_rdy),
    .mem_req_rw_o(mem_req_rw), .mem_resp_val_i(mem_resp_val), .mem_resp_rdy_o(mem_resp_rdy),
    .flush_i(flush), .flush_done_o(flush_done), .flush_idx_o(flush_idx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < S; s++) nextVictim[s] = 0;
  endtask

  task automatic modelTouch(input int idx, input int way);
    nextVictim[idx] = (way == 0) ? 1 : 0;
  endtask

  task automatic applyStimulus();
    memreq_val = 1'b0; memreq_type = 1'b0; memreq_idx = '0;
    memresp_rdy = 1'b1; tag_match = '0; dirty = '0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; flush = 1'b0;
  endtask

  task automatic runHit(input int idx, input bit wr, input int way, input int stall);
    @(negedge clk);
    memreq_val = 1'b1; memreq_type = wr; memreq_idx = 4'(idx);
    tag_match = 2'(1 << way); dirty = 2'($urandom_range(0, 3)); memresp_rdy = (stall == 0);
    #1;
    checkOutput("hit_memresp_val", memresp_val, 1);
    checkOutput("hit_way_sel", way_sel, way);
    checkOutput("hit_darray_wen", darray_wen, wr);
    checkOutput("hit_dirty_wen", dirty_wen, wr);
    checkOutput("hit_dirty_wdata", dirty_wdata, wr);
    modelTouch(idx, way);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      memreq_val = 1'b0; tag_match = '0;
      if (i == stall - 1) memresp_rdy = 1'b1;
      #1;
      checkOutput("resp_hold_val", memresp_val, 1);
      checkOutput("resp_hold_rdy", memreq_rdy, 0);
      checkOutput("resp_hold_dwen", darray_wen, 0);
    end
    @(negedge clk);
    memreq_val = 1'b0; tag_match = '0; memresp_rdy = 1'b1;
    #1 checkOutput("hit_back_idle", memreq_rdy, 1);
  endtask

  task automatic runMiss(input int idx, input bit wr, input logic [1:0] dv, input int stall, input int respDelay);
    int  expWay;
    bit  wb;
    expWay = nextVictim[idx];
    wb     = dv[expWay];
    @(negedge clk);
    memreq_val = 1'b1; memreq_type = wr; memreq_idx = 4'(idx); tag_match = '0; dirty = dv;
    #1;
    checkOutput("miss_rdy", memreq_rdy, 1);
    checkOutput("miss_no_resp", memresp_val, 0);
    @(negedge clk);
    memreq_val = 1'b0; memreq_type = ~wr; memreq_idx = 4'(idx + 1); mem_resp_val = 1'b1;
    #1;
    checkOutput("spurious_resp_rdy", mem_resp_rdy, 0);
    checkOutput("spurious_twen", tarray_wen, 0);
    mem_resp_val = 1'b0;
    if (wb) begin
      for (int i = 0; i < stall; i++) begin
        #1;
        checkOutput("evict_val", mem_req_val, 1);
        checkOutput("evict_rw", mem_req_rw, 1);
        checkOutput("evict_way", way_sel, expWay);
        checkOutput("evict_nowen", dirty_wen, 0);
        @(negedge clk);
      end
      mem_req_rdy = 1'b1;
      #1;
      checkOutput("evict_val_hs", mem_req_val, 1);
      checkOutput("evict_rw_hs", mem_req_rw, 1);
      checkOutput("evict_dirty_wen", dirty_wen, 1);
      checkOutput("evict_dirty_wdata", dirty_wdata, 0);
      @(negedge clk);
      mem_req_rdy = 1'b0;
    end
    #1;
    checkOutput("refill_req_val", mem_req_val, 1);
    checkOutput("refill_req_rw", mem_req_rw, 0);
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    for (int i = 0; i < respDelay; i++) begin
      #1;
      checkOutput("wait_resp_rdy", mem_resp_rdy, 1);
      checkOutput("wait_req_val", mem_req_val, 0);
      @(negedge clk);
    end
    mem_resp_val = 1'b1;
    #1;
    checkOutput("refill_twen", tarray_wen, 1);
    checkOutput("refill_dwen", darray_wen, 1);
    checkOutput("refill_way", way_sel, expWay);
    @(negedge clk);
    mem_resp_val = 1'b0; memresp_rdy = 1'b1;
    #1;
    checkOutput("miss_resp_val", memresp_val, 1);
    checkOutput("miss_resp_way", way_sel, expWay);
    checkOutput("miss_resp_dwen", darray_wen, wr);
    checkOutput("miss_resp_dirty_wen", dirty_wen, wr);
    checkOutput("miss_resp_dirty_wdata", dirty_wdata, wr);
    modelTouch(idx, expWay);
    @(negedge clk);
    #1 checkOutput("miss_back_idle", memreq_rdy, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    modelReset();
    reset_n = 1'b0;
    memreq_val = 1'b1; memreq_type = 1'b1; tag_match = 2'b01;
    #12;
    checkOutput("reset_memreq_rdy", memreq_rdy, 0);
    checkOutput("reset_memresp_val", memresp_val, 0);
    checkOutput("reset_darray_wen", darray_wen, 0);
    checkOutput("reset_dirty_wen", dirty_wen, 0);
    checkOutput("reset_mem_req_val", mem_req_val, 0);
    checkOutput("reset_flush_done", flush_done, 0);
    @(negedge clk);
    applyStimulus();
    reset_n = 1'b1;
    #1 checkOutput("post_reset_rdy", memreq_rdy, 1);

    runHit(3, 1'b1, 1, 0);
    runMiss(5, 1'b0, 2'b00, 0, 1);
    runMiss(5, 1'b0, 2'b00, 0, 0);
    runMiss(7, 1'b0, 2'b11, 4, 2);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        runHit($urandom_range(0, S - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 2));
      else
        runMiss($urandom_range(0, S - 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

`ifdef CACHE_ASSOC_CTRL_FLUSH_EN
    begin
      bit fd [S][W];
      int cyc = 0, valCycles = 0, wbs = 0, dones = 0, flushCycles = 0;
      for (int s = 0; s < S; s++) for (int w = 0; w < W; w++) fd[s][w] = 1'b0;
      fd[9][1] = 1'b1;
      @(negedge clk);
      flush = 1'b1; memreq_val = 1'b1; memreq_idx = 4'd2; tag_match = 2'b01;
      #1;
      checkOutput("flush_wins_rdy", memreq_rdy, 0);
      checkOutput("flush_wins_resp", memresp_val, 0);
      @(negedge clk);
      flush = 1'b0; memreq_val = 1'b0; tag_match = '0;
      while (dones == 0 && cyc < 200) begin
        dirty = {fd[flush_idx][1], fd[flush_idx][0]};
        #1;
        if (flush_done) dones++;
        else flushCycles++;
        if (mem_req_val) begin
          valCycles++;
          checkOutput("flush_wb_idx", flush_idx, 9);
          checkOutput("flush_wb_way", way_sel, 1);
          checkOutput("flush_wb_rw", mem_req_rw, 1);
          if (valCycles >= 3) begin
            mem_req_rdy = 1'b1;
            #1;
            checkOutput("flush_wb_dirty_wen", dirty_wen, 1);
            checkOutput("flush_wb_dirty_wdata", dirty_wdata, 0);
            wbs++;
            fd[9][1] = 1'b0;
          end
        end
        @(negedge clk);
        mem_req_rdy = 1'b0;
        cyc++;
      end
      dirty = '0;
      checkOutput("flush_done_seen", dones, 1);
      checkOutput("flush_writebacks", wbs, 1);
      checkOutput("flush_wb_valid_cycles", valCycles, 3);
      checkOutput("flush_walk_cycles", flushCycles, S * W + 2);
      #1;
      checkOutput("flush_done_pulse", flush_done, 0);
      checkOutput("flush_back_idle", memreq_rdy, 1);
    end
`else
    @(negedge clk);
    flush = 1'b1; memreq_val = 1'b1; memreq_type = 1'b0; memreq_idx = 4'd2; tag_match = 2'b01;
    #1;
    checkOutput("flush_ignored_rdy", memreq_rdy, 1);
    checkOutput("flush_ignored_resp", memresp_val, 1);
    checkOutput("flush_done_tied", flush_done, 0);
    checkOutput("flush_idx_tied", flush_idx, 0);
    modelTouch(2, 0);
    @(negedge clk);
    flush = 1'b0; memreq_val = 1'b0; tag_match = '0;
`endif

    runHit(5, 1'b0, 0, 0);
    @(negedge clk);
    memreq_val = 1'b1; memreq_type = 1'b0; memreq_idx = 4'd5; tag_match = '0; dirty = '0;
    @(negedge clk);
    memreq_val = 1'b0; mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    #1 checkOutput("abort_in_wait", mem_resp_rdy, 1);
    reset_n = 1'b0; mem_resp_val = 1'b1;
    #1;
    checkOutput("abort_resp_rdy", mem_resp_rdy, 0);
    checkOutput("abort_twen", tarray_wen, 0);
    checkOutput("abort_dwen", darray_wen, 0);
    checkOutput("abort_memreq_rdy", memreq_rdy, 0);
    checkOutput("abort_memresp_val", memresp_val, 0);
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1; mem_resp_val = 1'b0;
    #1 checkOutput("abort_release_rdy", memreq_rdy, 1);
    runMiss(5, 1'b1, 2'b10, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_assoc_ctrl.md
CACHE_ASSOC_CTRL -- requirements
Module: cache_assoc_ctrl

Interface
REQ-001 SHALL have parameter p_num_ways, default 2, meaning associativity; legal values are powers of two from 2 to 8.
REQ-002 SHALL have parameter p_num_sets, default 16, meaning sets per way; legal values are powers of two of at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memreq_val  input  1  processor request valid.
REQ-006 memreq_rdy  output  1  processor request ready.
REQ-007 memreq_type  input  1  0 = read, 1 = write.
REQ-008 memreq_idx  input  clog2(p_num_sets)  set index of the request.
REQ-009 memresp_val  output  1  processor response valid.
REQ-010 memresp_rdy  input  1  processor response ready.
REQ-011 tag_match  input  p_num_ways  one-hot, valid-qualified hit vector for the indexed set.
REQ-012 dirty  input  p_num_ways  dirty bits of the indexed set.
REQ-013 way_sel  output  clog2(p_num_ways)  way addressed by array writes and by write-back.
REQ-014 darray_wen / tarray_wen / dirty_wen  output  1 each  data, tag and dirty array write enables.
REQ-015 dirty_wdata  output  1  value written to the dirty bit.
REQ-016 mem_req_val / mem_req_rdy  output / input  1 each  memory-side line request handshake.
REQ-017 mem_req_rw  output  1  1 = write-back, 0 = refill read.
REQ-018 mem_resp_val / mem_resp_rdy  input / output  1 each  refill-data handshake.
REQ-019 flush / flush_done / flush_idx  input 1 / output 1 / output clog2(p_num_sets)  flush request, completion pulse, and set currently being walked.

Function
REQ-020 SHALL implement states IDLE, EVICT, REFILL_REQ, REFILL_WAIT, RESP, FLUSH and FLUSH_FIN.
REQ-021 memreq_rdy SHALL be 1 only in IDLE; the accepted type and idx SHALL be latched and used until the FSM returns to IDLE.
REQ-022 On a hit in IDLE, memresp_val SHALL assert in the acceptance cycle and way_sel SHALL equal the encoded tag_match; a write SHALL pulse darray_wen and dirty_wen with dirty_wdata=1; if memresp_rdy=0, the FSM SHALL go to RESP and hold there until memresp_rdy=1.
REQ-023 On a miss, the victim SHALL be the tree-PLRU way of the set; the FSM SHALL go to EVICT if dirty[victim]=1, else to REFILL_REQ.
REQ-024 EVICT SHALL drive mem_req_val=1 with mem_req_rw=1; on mem_req_rdy it SHALL pulse dirty_wen with dirty_wdata=0 and go to REFILL_REQ.
REQ-025 REFILL_REQ SHALL drive mem_req_val=1 with mem_req_rw=0 and go to REFILL_WAIT on mem_req_rdy.
REQ-026 REFILL_WAIT SHALL drive mem_resp_rdy=1; on mem_resp_val it SHALL pulse tarray_wen and darray_wen at the victim way and go to RESP, with the write then completing as a hit.
REQ-027 The PLRU bits of the accessed set SHALL update to point away from the accessed way on every hit and every refill; there SHALL be p_num_ways-1 bits per set.
REQ-028 mem_req_val SHALL remain asserted and stable until mem_req_rdy; a mem_resp_val arriving outside REFILL_WAIT SHALL be ignored.
REQ-029 If flush and memreq_val are both high in IDLE, flush SHALL win and memreq_rdy SHALL be 0 in that cycle.
REQ-030 FLUSH SHALL walk set 0..p_num_sets-1 and, within each set, way 0..p_num_ways-1, one way per cycle; a dirty way SHALL issue a write-back and clear its dirty bit, stalling the walk until mem_req_rdy.
REQ-031 FLUSH_FIN SHALL pulse flush_done for 1 cycle and then return to IDLE; a flush with no dirty lines SHALL take exactly p_num_sets*p_num_ways cycles in FLUSH.

Reset
REQ-032 While reset=0, the state SHALL be IDLE, all PLRU bits 0, and all outputs 0 except memreq_rdy; memreq_rdy SHALL be 1 only after reset deasserts.
REQ-033 A reset asserted mid-miss or mid-flush SHALL abort the transaction with no array write-enable pulse.

Configuration
REQ-034 With CACHE_ASSOC_CTRL_FLUSH_EN defined, flush SHALL behave per REQ-029 to REQ-031.
REQ-035 Without CACHE_ASSOC_CTRL_FLUSH_EN, the FLUSH and FLUSH_FIN states SHALL be absent, flush SHALL be ignored, and flush_done and flush_idx SHALL be tied to 0.

Verification
REQ-036 Bench SHALL use p_num_ways=2, p_num_sets=16; write hit at idx 3 with tag_match=2'b10 -> memresp_val the same cycle, way_sel=1, darray_wen=dirty_wen=1.
REQ-037 Read miss at idx 5 after reset with dirty=2'b00 -> refill at way 0 with no write-back; the next miss at idx 5 -> victim way 1.
REQ-038 Miss at idx 7 with dirty[victim]=1 and mem_req_rdy held 0 for 4 cycles -> mem_req_val stays 1 with rw=1 for all 4 cycles, then a refill read follows.
REQ-039 Flush with only set 9 way 1 dirty -> exactly one write-back occurs with flush_idx=9 and way_sel=1, followed by one flush_done pulse.
REQ-040 Reset asserted in REFILL_WAIT -> all outputs 0 immediately; after release, memreq_rdy=1 and a subsequent miss at the same set picks victim way 0.
